// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcode/funct
// fields, ALU control codes and datapath mux selects.
package mips_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
    } state_e;

    // ALU operation class handed from the FSM to the ALU decoder.
    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } alu_op_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctAnd = 6'b100100;
    localparam logic [5:0] FunctOr  = 6'b100101;
    localparam logic [5:0] FunctSlt = 6'b101010;
    localparam logic [5:0] FunctNor = 6'b100111;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluNor = 4'b1100;

    localparam logic [1:0] SrcBReg    = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBImmSh2 = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    // Opcodes every build supports; bne is added by the top when enabled.
    function automatic logic op_supported(input logic [5:0] op);
        return (op == OpRtype) || (op == OpLw) || (op == OpSw) || (op == OpBeq) ||
               (op == OpAddi) || (op == OpJ);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode: maps the FSM's ALU operation class and the
// R-type funct field to an ALUControl code, and flags unmapped funct values.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] Funct,
    input  logic [1:0] alu_op,
    output logic [3:0] ALUControl,
    output logic       funct_valid
);

    logic [3:0] funct_ctl;

    always_comb begin
        funct_ctl   = AluAdd;
        funct_valid = 1'b1;
        case (Funct)
            FunctAdd: funct_ctl = AluAdd;
            FunctSub: funct_ctl = AluSub;
            FunctAnd: funct_ctl = AluAnd;
            FunctOr:  funct_ctl = AluOr;
            FunctSlt: funct_ctl = AluSlt;
            FunctNor: funct_ctl = AluNor;
            default:  funct_valid = 1'b0;
        endcase
    end

    always_comb begin
        ALUControl = AluAdd;
        case (alu_op)
            AluOpSub:   ALUControl = AluSub;
            AluOpFunct: ALUControl = funct_ctl;
            default:    ALUControl = AluAdd;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM (Moore outputs plus combinational PCEn/Illegal).
// Define MC_CONTROL_BNE_EN to add bne support through the BRANCH state.
module mc_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [3:0] ALUControl,
    output logic       Illegal
);

    state_e  state_q, state_d;
    alu_op_e alu_op;
    logic    bne_en;
    logic    funct_valid;
    logic    decode_bad;
    logic    is_bne;
    logic    pc_write, branch, in_branch;
    logic    mem_write, ir_write, reg_write;

`ifdef MC_CONTROL_BNE_EN
    assign bne_en = 1'b1;
`else
    assign bne_en = 1'b0;
`endif

    // Op is the IR field, so it stays valid for the whole instruction.
    assign is_bne     = bne_en && (Op == OpBne);
    assign decode_bad = !(op_supported(Op) || is_bne) ||
                        ((Op == OpRtype) && !funct_valid);

    alu_decoder u_alu_decoder (
        .Funct       (Funct),
        .alu_op      (alu_op),
        .ALUControl  (ALUControl),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                if (decode_bad) begin
                    state_d = StFetch;
                end else begin
                    case (Op)
                        OpLw, OpSw: state_d = StMemAdr;
                        OpRtype:    state_d = StExecute;
                        OpBeq:      state_d = StBranch;
                        OpAddi:     state_d = StAddiEx;
                        OpJ:        state_d = StJump;
                        default:    state_d = is_bne ? StBranch : StFetch;
                    endcase
                end
            end
            StMemAdr:  state_d = (Op == OpSw) ? StMemWr : StMemRd;
            StMemRd:   state_d = StMemWb;
            StExecute: state_d = StAluWb;
            StAddiEx:  state_d = StAddiWb;
            default:   state_d = StFetch;
        endcase
    end

    always_comb begin
        IorD      = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        reg_write = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SrcBReg;
        PCSrc     = PcSrcAlu;
        pc_write  = 1'b0;
        in_branch = 1'b0;
        alu_op    = AluOpAdd;
        case (state_q)
            StFetch: begin
                ir_write = 1'b1;
                ALUSrcB  = SrcBFour;
                pc_write = 1'b1;
            end
            StDecode: ALUSrcB = SrcBImmSh2;
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SrcBImm;
            end
            StMemRd: IorD = 1'b1;
            StMemWb: begin
                MemtoReg  = 1'b1;
                reg_write = 1'b1;
            end
            StMemWr: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
            end
            StExecute: begin
                ALUSrcA = 1'b1;
                alu_op  = AluOpFunct;
            end
            StAluWb: begin
                RegDst    = 1'b1;
                reg_write = 1'b1;
            end
            StBranch: begin
                ALUSrcA   = 1'b1;
                alu_op    = AluOpSub;
                PCSrc     = PcSrcAluOut;
                in_branch = 1'b1;
            end
            StAddiEx: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SrcBImm;
            end
            StAddiWb: reg_write = 1'b1;
            StJump: begin
                PCSrc    = PcSrcJump;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables and the illegal pulse are held off while reset is asserted.
    assign branch   = in_branch && (is_bne ? !Zero : Zero);
    assign IRWrite  = ir_write && rst_n;
    assign MemWrite = mem_write && rst_n;
    assign RegWrite = reg_write && rst_n;
    assign PCEn     = (pc_write || branch) && rst_n;
    assign Illegal  = (state_q == StDecode) && decode_bad && rst_n;

endmodule

// File: tb/tb_mc_control.sv
// Randomized bench for mc_control against a per-instruction step-list reference model.
// Honours MC_CONTROL_BNE_EN the same way as the design.
module tb_mc_control;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] Op = 6'd0;
    logic [5:0] Funct = 6'd0;
    logic       Zero = 1'b0;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic       PCEn, Illegal;
    logic [3:0] ALUControl;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MC_CONTROL_BNE_EN
    localparam bit BneEn = 1'b1;
`else
    localparam bit BneEn = 1'b0;
`endif

    typedef struct packed {
        logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b, pc_src;
        logic       pc_en;
        logic [3:0] alu_ctl;
        logic       illegal;
    } ctl_t;

    ctl_t obs;
    assign obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, PCSrc, PCEn, ALUControl, Illegal};

    mc_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .PCEn       (PCEn),
        .ALUControl (ALUControl),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    // Instruction phases, used only as keys into the expected-output table.
    localparam int SF = 0, SD = 1, SMA = 2, SMR = 3, SMWB = 4, SMWR = 5, SEX = 6, SAWB = 7,
                   SBR = 8, SAEX = 9, SAIWB = 10, SJ = 11;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {valid, code}
    function automatic logic [4:0] funct_map(input logic [5:0] f);
        case (f)
            6'b100000: return 5'b1_0010;
            6'b100010: return 5'b1_0110;
            6'b100100: return 5'b1_0000;
            6'b100101: return 5'b1_0001;
            6'b101010: return 5'b1_0111;
            6'b100111: return 5'b1_1100;
            default:   return 5'b0_0010;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] f);
        logic [4:0] fm;
        fm = funct_map(f);
        case (op)
            6'b000000:                                  return fm[4];
            6'b100011, 6'b101011, 6'b000100, 6'b001000,
            6'b000010:                                  return 1'b1;
            6'b000101:                                  return BneEn;
            default:                                    return 1'b0;
        endcase
    endfunction

    function automatic ctl_t exp_ctl(input int step, input logic [5:0] op, input logic [5:0] f,
                                     input logic z);
        ctl_t       c;
        logic [4:0] fm;
        c = '0;
        c.alu_ctl = 4'b0010;
        fm = funct_map(f);
        case (step)
            SF:    begin c.ir_write = 1; c.alu_src_b = 2'b01; c.pc_en = 1; end
            SD:    begin c.alu_src_b = 2'b11; c.illegal = !is_legal(op, f); end
            SMA:   begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            SMR:   c.iord = 1;
            SMWB:  begin c.mem_to_reg = 1; c.reg_write = 1; end
            SMWR:  begin c.iord = 1; c.mem_write = 1; end
            SEX:   begin c.alu_src_a = 1; c.alu_ctl = fm[3:0]; end
            SAWB:  begin c.reg_dst = 1; c.reg_write = 1; end
            SBR:   begin
                c.alu_src_a = 1; c.alu_ctl = 4'b0110; c.pc_src = 2'b01;
                c.pc_en = (op == 6'b000101) ? !z : z;
            end
            SAEX:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            SAIWB: c.reg_write = 1;
            SJ:    begin c.pc_src = 2'b10; c.pc_en = 1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctl_t reset_ctl();
        ctl_t c;
        c = exp_ctl(SF, 6'd0, 6'd0, 1'b0);
        c.ir_write = 0;
        c.pc_en = 0;
        return c;
    endfunction

    // Called shortly after a negedge with the DUT in FETCH. zmode<0 randomizes Zero.
    // abort_at>=0 pulses reset at that step instead of finishing the instruction.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input int zmode,
                             input int abort_at);
        int   steps[$];
        ctl_t e;
        if (!is_legal(op, f)) steps = '{SF, SD};
        else begin
            case (op)
                6'b100011: steps = '{SF, SD, SMA, SMR, SMWB};
                6'b101011: steps = '{SF, SD, SMA, SMWR};
                6'b000000: steps = '{SF, SD, SEX, SAWB};
                6'b001000: steps = '{SF, SD, SAEX, SAIWB};
                6'b000010: steps = '{SF, SD, SJ};
                default:   steps = '{SF, SD, SBR};
            endcase
        end
        Op = op;
        Funct = f;
        foreach (steps[i]) begin
            Zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1 check_eq($sformatf("rst_assert op=%b step=%0d", op, i), 32'(obs),
                            32'(reset_ctl()));
                @(negedge clk);
                #1 check_eq($sformatf("rst_hold op=%b", op), 32'(obs), 32'(reset_ctl()));
                rst_n = 1'b1;
                return;
            end
            e = exp_ctl(steps[i], op, f, Zero);
            #1 check_eq($sformatf("op=%b fn=%b step=%0d z=%b", op, f, steps[i], Zero),
                        32'(obs), 32'(e));
            @(negedge clk);
        end
    endtask

    localparam logic [5:0] OpList[8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                         6'b001000, 6'b000010, 6'b000101, 6'b111111};
    localparam logic [5:0] FnList[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                         6'b101010, 6'b100111};

    initial begin
        logic [5:0] op, f;
        int         abort;
        #3 check_eq("reset_state", 32'(obs), 32'(reset_ctl()));
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(6'b000000, 6'b100000, -1, -1);  // add
        run_instr(6'b100011, 6'b000000, -1, -1);  // lw
        run_instr(6'b000100, 6'b000000, 1, -1);   // beq taken
        run_instr(6'b000100, 6'b000000, 0, -1);   // beq not taken
        run_instr(6'b111111, 6'b000000, -1, -1);  // illegal op
        run_instr(6'b000000, 6'b111111, -1, -1);  // illegal funct
        run_instr(6'b000101, 6'b000000, 0, -1);   // bne, Zero=0
        run_instr(6'b100011, 6'b000000, -1, 3);   // reset during MEMRD
        run_instr(6'b101011, 6'b000000, -1, -1);  // sw after reset
        for (int n = 0; n < 300; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : OpList[$urandom_range(0, 7)];
            f  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : FnList[$urandom_range(0, 5)];
            abort = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(op, f, -1, abort);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameters: none; all encodings are fixed constants from the shared package.
REQ-002 clk  input  1  rising-edge system clock, the only clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 Op  input  6  instruction opcode field, IR[31:26].
REQ-005 Funct  input  6  instruction function field, IR[5:0].
REQ-006 Zero  input  1  ALU zero flag, 1 when ALUResult == 0.
REQ-007 IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 MemWrite  output  1  data memory write enable.
REQ-009 IRWrite  output  1  instruction register load enable.
REQ-010 RegDst  output  1  register write address select: 0 = rt, 1 = rd.
REQ-011 MemtoReg  output  1  register write data select: 0 = ALUOut, 1 = Data.
REQ-012 RegWrite  output  1  register file write enable.
REQ-013 ALUSrcA  output  1  ALU A select: 0 = PC, 1 = A register.
REQ-014 ALUSrcB  output  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
REQ-015 PCSrc  output  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
REQ-016 PCEn  output  1  PC load enable.
REQ-017 ALUControl  output  4  ALU operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
REQ-018 Illegal  output  1  one-cycle pulse on an unsupported Op or Funct.

Function
REQ-019 The state machine SHALL be a Moore machine with one state register. All outputs decode combinationally from that register, except PCEn and Illegal.
REQ-020 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-021 FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, PCSrc=00, PCWrite=1; the next state is DECODE.
REQ-022 DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=ADD. Next state by Op:
  - lw (100011) or sw (101011) -> MEMADR
  - R-type (000000) -> EXECUTE
  - beq (000100) -> BRANCH
  - addi (001000) -> ADDIEX
  - j (000010) -> JUMP
  - any other Op -> FETCH
REQ-023 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD. Next state is MEMRD for lw, MEMWR for sw.
REQ-024 MEMRD: IorD=1, next MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, next FETCH.
REQ-025 MEMWR: IorD=1, MemWrite=1, next FETCH.
REQ-026 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct, next ALUWB. Funct mapping:
  - 100000 -> ADD; 100010 -> SUB; 100100 -> AND
  - 100101 -> OR; 101010 -> SLT; 100111 -> NOR
REQ-027 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, next FETCH.
REQ-028 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=SUB, PCSrc=01, Branch=1, next FETCH.
REQ-029 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, next ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, next FETCH.
REQ-030 JUMP: PCSrc=10, PCWrite=1, next FETCH.
REQ-031 Any output not listed for a state SHALL be 0, with ALUControl=ADD; encoding 0010 is the default.
REQ-032 PCEn = PCWrite | (Branch & Zero), evaluated combinationally in the current cycle.
REQ-033 Illegal SHALL be 1 in DECODE when Op is unsupported, or when Op=000000 and Funct is unmapped. In both cases the next state is FETCH and no write enable is asserted.
REQ-034 Cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-035 Unreachable state encodings SHALL transition to FETCH on the next edge.

Reset
REQ-036 While rst_n=0, the state register SHALL be FETCH (asynchronous assertion). IRWrite, PCEn, MemWrite, RegWrite and Illegal SHALL be forced to 0.
REQ-037 Reset asserted mid-instruction SHALL abandon that instruction; the first edge after release executes FETCH.

Configuration
REQ-038 Macro MC_CONTROL_BNE_EN SHALL control support for bne.
  - Defined: Op 000101 goes to BRANCH with a BranchNe flag, and PCEn additionally ORs in (BranchNe & ~Zero).
  - Undefined: 000101 is illegal per REQ-033.

Structure
REQ-039 Package mips_pkg SHALL hold:
  - the state enum
  - Op and Funct localparams
  - ALUControl codes
  - ALUSrcB and PCSrc encodings
REQ-040 Sub-module alu_decoder SHALL be combinational: inputs Funct plus an ALUOp class from the FSM; outputs ALUControl and funct_valid.

Verification
REQ-041 add (Op=000000, Funct=100000), Zero=x: FETCH, DECODE, EXECUTE with ALUControl=0010, then ALUWB with RegWrite=1 and RegDst=1; 4 cycles.
REQ-042 lw (Op=100011): 5 cycles; MEMRD IorD=1; MEMWB MemtoReg=1, RegWrite=1; MemWrite stays 0.
REQ-043 beq (Op=000100):
  - With Zero=1: PCEn=1 and PCSrc=01 in BRANCH.
  - With Zero=0: PCEn=0.
  - In both cases, the next state is FETCH.
REQ-044 Op=111111: Illegal=1 in DECODE for one cycle, then FETCH; RegWrite and MemWrite are never 1.
REQ-045 rst_n driven low during MEMRD of lw: state reads FETCH immediately, with write enables 0. After release, FETCH outputs appear (IRWrite=1, PCEn=1).
REQ-046 Op=000101 with Zero=0:
  - Macro defined: PCEn=1 in BRANCH.
  - Macro undefined: Illegal=1 in DECODE.
